uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx instance between N_REQ byte-stream requesters.
//  - Sits between client logic (loopback echo, status reporter, debug dumper) and the uart_tx data_in_* port.
//  - Round-robin arbitration with a registered one-hot grant.
//  - Optional packet locking, so multi-byte messages are not interleaved.
// PARAMETERS
//  N_REQ        2    number of requesters, 2..8
//  MAX_BURST    16   lock mode only: max bytes per grant before forced release, >=1
//  IDLE_TIMEOUT 255  lock mode only: cycles the granted requester may hold valid low mid-packet before release
// PORTS
//  clk        in   1        system clock
//  rst_n      in   1        asynchronous active-low reset
//  req_data   in   8*N_REQ  byte from requester i at [8*i+7:8*i]
//  req_valid  in   N_REQ    requester i offers req_data slice
//  req_last   in   N_REQ    final byte of a message; used only with UART_ARB_LOCK_EN
//  req_ready  out  N_REQ    byte of requester i accepted this cycle
//  tx_data    out  8        to uart_tx data_in
//  tx_valid   out  1        to uart_tx data_in_valid
//  tx_ready   in   1        from uart_tx data_in_ready
//  grant      out  N_REQ    one-hot current grant, 0 when idle (LED/debug)
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, grant=0, ptr=N_REQ-1 (requester 0 wins first), burst_cnt=0, idle_cnt=0.
//    Outputs during reset: tx_valid=0, req_ready=0, busy=0.
//  - Handshake: a transfer occurs when tx_valid & tx_ready are both high on a clk edge.
//  - IDLE:
//    - If any req_valid is set, pick the first valid requester searching ptr+1, ptr+2, ... modulo N_REQ.
//    - Register the pick into grant, move to GRANT. Arbitration latency is 1 cycle.
//    - tx_valid=0 while in IDLE.
//  - GRANT, with g = granted index:
//    - Outputs: tx_data=req_data[g], tx_valid=req_valid[g], req_ready[g]=tx_ready; every other req_ready=0. These are combinational from grant.
//    - On a transfer: ptr<=g.
//  - No-lock mode: after each transfer, grant<=0 and return to IDLE. This gives byte-level round-robin.
//    Each byte costs 1 idle arbitration cycle, which is negligible against the UART bit time.
//  - Lock mode: GRANT persists until one of the following releases it (grant<=0, back to IDLE):
//    - a transfer with req_last[g]=1;
//    - a transfer where burst_cnt reaches MAX_BURST-1;
//    - idle_cnt reaching IDLE_TIMEOUT.
//    - burst_cnt increments per transfer and clears on release.
//    - idle_cnt increments each GRANT cycle with req_valid[g]=0, clears on req_valid[g]=1, and clears on release.
//  - Simultaneous events:
//    - The release and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle, never the same cycle.
//  - Stable data: clients must keep data stable while valid & !ready. The arbiter never withdraws tx_valid while tx_ready=0, except on an idle timeout, when valid is already low.
//  - Mid-operation reset: takes effect immediately. A byte already latched by uart_tx still completes on the line; the arbiter does not track it.
//  - Widths:
//    - ptr is $clog2(N_REQ) bits and wraps N_REQ-1 -> 0.
//    - burst_cnt is $clog2(MAX_BURST+1) bits.
//    - idle_cnt is $clog2(IDLE_TIMEOUT+1) bits and saturates.
// CONFIGURATION
//  `UART_ARB_LOCK_EN` defined:
//   - Packet lock is active: req_last, MAX_BURST and IDLE_TIMEOUT apply.
//  Undefined:
//   - Byte-level round-robin only. req_last is ignored.
//   - burst_cnt and idle_cnt are not instantiated.
// STRUCTURE
//  - Package uart_pkg holds:
//    - UART_BYTE_W=8;
//    - the arbiter state enum {ARB_IDLE, ARB_GRANT};
//    - the localparam-derived counter widths.
//  - Sub-module rr_picker holds the round-robin search:
//    - purely combinational;
//    - inputs: req mask [N_REQ], ptr;
//    - outputs: one-hot pick, any_valid.
//  - The top level holds the FSM, counters and output muxing.
// TESTING
//  1. Reset and idle: rst_n=0 for 3 cycles with req_valid=2'b11 -> grant=0, tx_valid=0, req_ready=0.
//     After release, the first grant is 2'b01.
//  2. Fairness, no lock: both requesters are continuously valid with tx_ready pulsing -> tx_data alternates A0,B0,A1,B1.
//     Each req_ready pulse matches exactly one transfer.
//  3. Backpressure: tx_ready=0 for 50 cycles while granted -> tx_valid stays 1, tx_data is stable, grant is unchanged, no req_ready.
//  4. Lock (UART_ARB_LOCK_EN): req0 sends 3 bytes with last on byte 3 while req1 is valid -> bytes 0x10,0x11,0x12 go out contiguously, then req1.
//  5. Lock burst cap: MAX_BURST=4, req0 streams 10 bytes without last while req1 is valid -> grant switches to req1 after the 4th byte.
//  6. Lock timeout: IDLE_TIMEOUT=8, req0 drops valid mid-packet -> grant is released after 8 idle cycles and req1 is served.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit arbiter.
// Packet lock is enabled by defining UART_ARB_LOCK_EN.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  localparam int ARB_MAX_BURST_DEF    = 16;
  localparam int ARB_IDLE_TIMEOUT_DEF = 255;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int ARB_BURST_W_DEF = cnt_w(ARB_MAX_BURST_DEF);
  localparam int ARB_IDLE_W_DEF  = cnt_w(ARB_IDLE_TIMEOUT_DEF);

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: first set request after ptr, wrapping.
// Purely combinational; the caller registers the result.
module rr_picker #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         pick,
  output logic                     any_valid
);

  localparam int PW = $clog2(N_REQ);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart_tx among N_REQ byte streams.
// Define UART_ARB_LOCK_EN for packet lock (last/burst/timeout).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int MAX_BURST    = ARB_MAX_BURST_DEF,
  parameter int IDLE_TIMEOUT = ARB_IDLE_TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]       tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [N_REQ-1:0]             grant,
  output logic                         busy
);

  localparam int PW = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    gidx;
  logic [N_REQ-1:0] pick;
  logic             any_valid;
  logic             g_valid;
  logic             xfer;
  logic             rel;

  rr_picker #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req      (req_valid),
    .ptr      (ptr_q),
    .pick     (pick),
    .any_valid(any_valid)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) gidx = PW'(i);
    end
  end

  assign g_valid = |(req_valid & grant_q);
  assign xfer    = tx_valid & tx_ready;

`ifdef UART_ARB_LOCK_EN
  localparam int BW = cnt_w(MAX_BURST);
  localparam int IW = cnt_w(IDLE_TIMEOUT);
  localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_END  = IW'(IDLE_TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);

  logic [BW-1:0] burst_q;
  logic [IW-1:0] idle_q;
  logic          g_last;
  logic          t_out;

  assign g_last = |(req_last & grant_q);
  // Timeout fires on the cycle that takes idle_q up to IDLE_TIMEOUT.
  assign t_out  = (state_q == ARB_GRANT) & ~g_valid &
                  (idle_q == IDLE_END);
  assign rel    = (xfer & (g_last | (burst_q == BURST_END))) | t_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q <= '0;
      idle_q  <= '0;
    end else if (state_q != ARB_GRANT || rel) begin
      burst_q <= '0;
      idle_q  <= '0;
    end else begin
      if (xfer) burst_q <= burst_q + 1'b1;
      if (g_valid) idle_q <= '0;
      else if (idle_q != IDLE_MAX) idle_q <= idle_q + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign rel        = xfer;
  assign unused_cfg = ^{req_last, MAX_BURST[0], IDLE_TIMEOUT[0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (any_valid) begin
          grant_d = pick;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (xfer) ptr_d = gidx;
        if (rel) begin
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (state_q == ARB_GRANT) begin
      tx_valid  = g_valid;
      req_ready = grant_q & {N_REQ{tx_ready}};
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_q[i])
          tx_data = req_data[UART_BYTE_W*i +: UART_BYTE_W];
      end
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter, two requesters.
// Lock-mode steps build only with UART_ARB_LOCK_EN.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req_data;
  logic [1:0]  req_valid;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ       (2),
    .MAX_BURST   (4),
    .IDLE_TIMEOUT(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_data (req_data),
    .req_valid(req_valid),
    .req_last (req_last),
    .req_ready(req_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .grant    (grant),
    .busy     (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pos1();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_b [4];
  logic [1:0] exp_g [4];

  initial begin
    exp_b = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};

    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_last  = 2'b11;
    req_data  = {8'hB0, 8'hA0};
    tx_ready  = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_grant", grant, 2'b00);
      chk("rst_txv", tx_valid, 1'b0);
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_busy", busy, 1'b0);
    end
    pos1();
    rst_n = 1'b1;
    @(negedge clk);
    chk("arb_latency", {grant, busy}, {2'b00, 1'b0});
    @(negedge clk);
    chk("first_grant", grant, 2'b01);
    chk("first_data", {tx_valid, tx_data}, {1'b1, 8'hA0});

    repeat (50) begin
      @(negedge clk);
      chk("backpressure", {grant, tx_valid, tx_data, req_ready},
          {2'b01, 1'b1, 8'hA0, 2'b00});
    end

    pos1();
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_grant", grant, exp_g[i]);
      chk("rr_data", tx_data, exp_b[i]);
      chk("rr_ready", req_ready, exp_g[i]);
      pos1();
      if (exp_g[i] == 2'b01) req_data[7:0] = req_data[7:0] + 8'd1;
      else req_data[15:8] = req_data[15:8] + 8'd1;
      if (i == 3) req_valid = 2'b00;
      @(negedge clk);
      chk("rr_idle", {grant, tx_valid, req_ready}, 5'd0);
      pos1();
    end

`ifndef UART_ARB_LOCK_EN
    req_last      = 2'b00;
    req_data[7:0] = 8'h5A;
    req_valid     = 2'b01;
    pos1();
    @(negedge clk);
    chk("nolock_grant", {grant, tx_data}, {2'b01, 8'h5A});
    pos1();
    req_valid = 2'b00;
    @(negedge clk);
    chk("nolock_release", {grant, busy}, {2'b00, 1'b0});
`else
    req_last  = 2'b10;
    req_data  = {8'hB5, 8'h10};
    req_valid = 2'b11;
    @(negedge clk);
    chk("lock_arb_lat", grant, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lock_grant", grant, 2'b01);
      chk("lock_data", tx_data, 8'(8'h10 + k));
      pos1();
      req_data[7:0] = 8'(8'h11 + k);
      req_last[0]   = (k == 1);
      if (k == 2) req_valid[0] = 1'b0;
    end
    @(negedge clk);
    chk("lock_release", grant, 2'b00);
    @(negedge clk);
    chk("lock_next", {grant, tx_data}, {2'b10, 8'hB5});
    pos1();

    req_data  = {8'hC0, 8'h20};
    req_last  = 2'b10;
    req_valid = 2'b11;
    @(negedge clk);
    chk("burst_idle", grant, 2'b00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("burst_grant", grant, 2'b01);
      chk("burst_data", tx_data, 8'(8'h20 + k));
      pos1();
      req_data[7:0] = req_data[7:0] + 8'd1;
    end
    @(negedge clk);
    chk("burst_release", grant, 2'b00);
    @(negedge clk);
    chk("burst_switch", {grant, tx_data}, {2'b10, 8'hC0});
    pos1();
    req_data[15:8] = 8'hC1;
    @(negedge clk);
    chk("burst_idle2", grant, 2'b00);
    @(negedge clk);
    chk("burst_resume", {grant, tx_data}, {2'b01, 8'h24});
    pos1();
    req_valid = 2'b10;

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("tout_hold", {grant, tx_valid}, {2'b01, 1'b0});
    end
    @(negedge clk);
    chk("tout_release", grant, 2'b00);
    @(negedge clk);
    chk("tout_next", {grant, tx_data}, {2'b10, 8'hC1});
    pos1();
    req_valid = 2'b00;
    @(negedge clk);
    chk("tout_done", {grant, busy}, {2'b00, 1'b0});
`endif

    req_data[7:0] = 8'h77;
    req_valid     = 2'b01;
    @(negedge clk);
    chk("mid_grant", {grant, tx_data}, {2'b01, 8'h77});
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", grant, 2'b00);
    chk("mid_rst_out", {tx_valid, req_ready, busy}, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
